// File: rtl/mlops_pkg.sv
// Shared types and helpers for the mlops vector datapath.
// Holds the vector-processor state enum and saturation bounds.
package mlops_pkg;

    typedef enum logic {
        WAITING    = 1'b0,
        PROCESSING = 1'b1
    } vproc_state_t;

    function automatic int sat_max(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int sat_min(input int n);
        return -(1 << (n - 1));
    endfunction

endpackage

// File: rtl/lane_shift_sat.sv
// One combinational lane: arithmetic right shift or saturating left shift.
// V_SHIFT_SAT_ROUND_EN selects round-half-up right shifts instead of floor.
module lane_shift_sat
    import mlops_pkg::*;
#(
    parameter int NBits = 8,
    parameter int AW    = $clog2(NBits) + 1
)(
    input  logic [NBits-1:0] data,
    input  logic [AW-1:0]    amt,
    input  logic             left,
    input  logic             valid,
    output logic [NBits-1:0] result,
    output logic             sat
);

    localparam int W2 = 2 * NBits;
    localparam logic [AW-1:0] AMT_FULL = AW'(NBits);
    localparam logic signed [W2-1:0] HI = W2'(sat_max(NBits));
    localparam logic signed [W2-1:0] LO = W2'(sat_min(NBits));

    logic signed [NBits-1:0] x;
    logic signed [W2-1:0]    wide;
    logic        [NBits-1:0] shr;

    assign x = data;

`ifdef V_SHIFT_SAT_ROUND_EN
    logic signed [NBits:0] ext;
    logic signed [NBits:0] bias;
    logic signed [NBits:0] rsum;
    logic signed [NBits:0] rsh;

    // Right shift with a half-LSB bias added first; huge amounts give 0.
    always_comb begin
        ext  = {x[NBits-1], x};
        bias = '0;
        if (amt != '0) begin
            bias = (NBits + 1)'(1) << (amt - AW'(1));
        end
        rsum = ext + bias;
        rsh  = rsum >>> amt;
        if (amt >= AMT_FULL) begin
            shr = '0;
        end else begin
            shr = rsh[NBits-1:0];
        end
    end
`else
    logic signed [NBits-1:0] tsh;

    // Floor right shift; huge amounts collapse to the sign fill.
    always_comb begin
        tsh = x >>> amt;
        if (amt >= AMT_FULL) begin
            shr = {NBits{x[NBits-1]}};
        end else begin
            shr = tsh;
        end
    end
`endif

    // Select shift direction, clamp left shifts, and blank unused lanes.
    always_comb begin
        wide   = {{NBits{x[NBits-1]}}, x} <<< amt;
        result = '0;
        sat    = 1'b0;
        if (valid) begin
            if (left) begin
                if (amt >= AMT_FULL) begin
                    if (x != '0) begin
                        sat    = 1'b1;
                        result = x[NBits-1] ? LO[NBits-1:0] : HI[NBits-1:0];
                    end
                end else if (wide > HI) begin
                    sat    = 1'b1;
                    result = HI[NBits-1:0];
                end else if (wide < LO) begin
                    sat    = 1'b1;
                    result = LO[NBits-1:0];
                end else begin
                    result = wide[NBits-1:0];
                end
            end else begin
                result = shr;
            end
        end
    end

endmodule

// File: rtl/v_shift_sat.sv
// Streaming vector shift unit: chunked shift/saturate with a registered output.
// Optional build macro V_SHIFT_SAT_ROUND_EN enables rounded right shifts.
module v_shift_sat
    import mlops_pkg::*;
#(
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 8
)(
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         in_data_ready,
    input  logic [WorkingRegs*NBits-1:0] in_data,
    input  logic [$clog2(NBits):0]       shift_amt,
    input  logic                         shift_left,
    input  logic                         out_full,
    output logic                         req_chunk_in,
    output logic [WorkingRegs*NBits-1:0] write_out_data,
    output logic                         req_chunk_out,
    output logic                         out_vector_valid,
    output logic                         out_sat
);

    localparam int AW        = $clog2(NBits) + 1;
    localparam int NChunks   = (InVecLength + WorkingRegs - 1) / WorkingRegs;
    localparam int LastLanes = InVecLength - (NChunks - 1) * WorkingRegs;
    localparam int CW        = (NChunks > 1) ? $clog2(NChunks) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NChunks - 1);

    vproc_state_t state;
    vproc_state_t state_nxt;

    logic [CW-1:0]                chunk_idx;
    logic [AW-1:0]                amt_q;
    logic [AW-1:0]                amt_cur;
    logic                         left_q;
    logic                         left_cur;
    logic                         sat_acc;
    logic                         sat_base;
    logic                         chunk_sat;
    logic                         accept;
    logic                         last_chunk;
    logic [WorkingRegs*NBits-1:0] lanes_out;
    logic [WorkingRegs-1:0]       lane_sat;
    logic [WorkingRegs-1:0]       lane_valid;

    assign accept       = in_data_ready && !out_full && !rst_in;
    assign req_chunk_in = accept;

    // Chunk 0 uses live parameters; later chunks use the latched copy.
    assign amt_cur    = (state == WAITING) ? shift_amt : amt_q;
    assign left_cur   = (state == WAITING) ? shift_left : left_q;
    assign last_chunk = (chunk_idx == LAST_IDX);
    assign sat_base   = (state == WAITING) ? 1'b0 : sat_acc;
    assign chunk_sat  = |lane_sat;

    for (genvar i = 0; i < WorkingRegs; i++) begin : g_lane
        assign lane_valid[i] = !last_chunk || (i < LastLanes);

        lane_shift_sat #(
            .NBits (NBits),
            .AW    (AW)
        ) u_lane (
            .data   (in_data[i*NBits +: NBits]),
            .amt    (amt_cur),
            .left   (left_cur),
            .valid  (lane_valid[i]),
            .result (lanes_out[i*NBits +: NBits]),
            .sat    (lane_sat[i])
        );
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= WAITING;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: stay busy until the last chunk of the vector is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            WAITING: begin
                if (accept && !last_chunk) begin
                    state_nxt = PROCESSING;
                end
            end
            PROCESSING: begin
                if (accept && last_chunk) begin
                    state_nxt = WAITING;
                end
            end
            default: state_nxt = WAITING;
        endcase
    end

    // Chunk counter, latched shift parameters and sticky saturation.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            chunk_idx <= '0;
            amt_q     <= '0;
            left_q    <= 1'b0;
            sat_acc   <= 1'b0;
        end else if (accept) begin
            if (state == WAITING) begin
                amt_q  <= shift_amt;
                left_q <= shift_left;
            end
            chunk_idx <= last_chunk ? '0 : chunk_idx + CW'(1);
            sat_acc   <= sat_base | chunk_sat;
        end
    end

    // Output stage: one write per accepted chunk, flags on the last one.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            write_out_data   <= '0;
            req_chunk_out    <= 1'b0;
            out_vector_valid <= 1'b0;
            out_sat          <= 1'b0;
        end else begin
            req_chunk_out    <= accept;
            out_vector_valid <= accept && last_chunk;
            out_sat          <= accept && last_chunk && (sat_base | chunk_sat);
            if (accept) begin
                write_out_data <= lanes_out;
            end
        end
    end

endmodule

// File: tb/tb_v_shift_sat.sv
// Directed bench for v_shift_sat (10 elements, 4 lanes, 8-bit).
// Expected values are hand-computed; a small integer model covers random gaps.
module tb_v_shift_sat;

    logic        clk;
    logic        rst;
    logic        in_data_ready;
    logic [31:0] in_data;
    logic [3:0]  shift_amt;
    logic        shift_left;
    logic        out_full;
    logic        req_chunk_in;
    logic [31:0] write_out_data;
    logic        req_chunk_out;
    logic        out_vector_valid;
    logic        out_sat;

    int n_pass;
    int n_tot;
    int n_fail;
    int n_vv;

    v_shift_sat #(
        .InVecLength (10),
        .WorkingRegs (4),
        .NBits       (8)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .in_data_ready    (in_data_ready),
        .in_data          (in_data),
        .shift_amt        (shift_amt),
        .shift_left       (shift_left),
        .out_full         (out_full),
        .req_chunk_in     (req_chunk_in),
        .write_out_data   (write_out_data),
        .req_chunk_out    (req_chunk_out),
        .out_vector_valid (out_vector_valid),
        .out_sat          (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int floor_div(input int x, input int d);
        int q;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] mlane(input int x, input int amt,
                                         input bit lft, output bit s);
        int v;
        s = 1'b0;
        if (lft) begin
            if (amt >= 8) begin
                v = (x == 0) ? 0 : ((x < 0) ? -128 : 127);
                s = (x != 0);
            end else begin
                v = x * (1 << amt);
                if (v > 127) begin
                    v = 127;
                    s = 1'b1;
                end else if (v < -128) begin
                    v = -128;
                    s = 1'b1;
                end
            end
        end else begin
`ifdef V_SHIFT_SAT_ROUND_EN
            if (amt == 0) v = x;
            else if (amt >= 8) v = 0;
            else v = floor_div(x + (1 << (amt - 1)), 1 << amt);
`else
            if (amt >= 8) v = (x < 0) ? -1 : 0;
            else v = floor_div(x, 1 << amt);
`endif
        end
        return 8'(v);
    endfunction

    function automatic logic [31:0] mchunk(input logic [31:0] d, input int amt,
                                           input bit lft, input int nvalid,
                                           output bit s);
        logic [31:0] r;
        bit          ls;
        int          x;
        r = '0;
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < nvalid) begin
                x = int'($signed(d[i*8 +: 8]));
                r[i*8 +: 8] = mlane(x, amt, lft, ls);
                s = s | ls;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input string tag, input logic [31:0] d,
                        input int amt, input bit lft,
                        input logic [31:0] ed, input bit evv, input bit esat);
        in_data       = d;
        shift_amt     = 4'(amt);
        shift_left    = lft;
        in_data_ready = 1'b1;
        #1;
        chk({tag, "_req_in"}, 32'(req_chunk_in), 32'd1);
        cyc();
        chk({tag, "_req_out"}, 32'(req_chunk_out), 32'd1);
        chk({tag, "_data"}, write_out_data, ed);
        chk({tag, "_vv"}, 32'(out_vector_valid), 32'(evv));
        chk({tag, "_sat"}, 32'(out_sat), 32'(esat));
    endtask

    logic [31:0] e_r2;
    logic [31:0] e_r4;
    logic [31:0] rd;
    logic [31:0] rexp;
    bit          rs;
    bit          racc;
    bit          rlft;
    int          ramt;
    int          rgap;

    initial begin
        n_pass = 0;
        n_tot  = 0;
        n_fail = 0;
        n_vv   = 0;
`ifdef V_SHIFT_SAT_ROUND_EN
        e_r2 = pk(2, -2, 2, -2);
        e_r4 = pk(4, -4, 0, 0);
`else
        e_r2 = pk(2, -2, 1, -2);
        e_r4 = pk(4, -4, 0, -1);
`endif

        // reset
        rst           = 1'b1;
        in_data_ready = 1'b1;
        in_data       = pk(1, 2, 3, 4);
        shift_amt     = 4'd0;
        shift_left    = 1'b0;
        out_full      = 1'b0;
        #1;
        chk("rst_req_in", 32'(req_chunk_in), 32'd0);
        cyc();
        cyc();
        chk("rst_data", write_out_data, 32'd0);
        chk("rst_req_out", 32'(req_chunk_out), 32'd0);
        chk("rst_vv", 32'(out_vector_valid), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        rst           = 1'b0;
        in_data_ready = 1'b0;
        cyc();

        // right 2, back-to-back
        xfer("r2_c0", pk(8, -8, 7, -7), 2, 1'b0, e_r2, 1'b0, 1'b0);
        xfer("r2_c1", pk(8, -8, 7, -7), 2, 1'b0, e_r2, 1'b0, 1'b0);
        xfer("r2_c2", pk(8, -8, 7, -7), 2, 1'b0, pk(2, -2, 0, 0), 1'b1, 1'b0);
        in_data_ready = 1'b0;
        cyc();
        chk("r2_idle", 32'(req_chunk_out), 32'd0);

        // left 3 saturating, then left 1 with sticky cleared
        xfer("l3_c0", pk(20, -20, 15, 1), 3, 1'b1, pk(127, -128, 120, 8), 1'b0, 1'b0);
        xfer("l3_c1", pk(1, 1, 1, 1), 3, 1'b1, pk(8, 8, 8, 8), 1'b0, 1'b0);
        xfer("l3_c2", pk(2, -1, 99, 99), 3, 1'b1, pk(16, -8, 0, 0), 1'b1, 1'b1);
        xfer("l1_c0", pk(3, 3, 3, 3), 1, 1'b1, pk(6, 6, 6, 6), 1'b0, 1'b0);
        xfer("l1_c1", pk(3, 3, 3, 3), 1, 1'b1, pk(6, 6, 6, 6), 1'b0, 1'b0);
        xfer("l1_c2", pk(3, 3, 100, 100), 1, 1'b1, pk(6, 6, 0, 0), 1'b1, 1'b0);

        // shift_amt change mid-vector is ignored
        xfer("amt_c0", pk(64, -64, 6, -6), 1, 1'b0, pk(32, -32, 3, -3), 1'b0, 1'b0);
        xfer("amt_c1", pk(64, -64, 6, -6), 4, 1'b0, pk(32, -32, 3, -3), 1'b0, 1'b0);
        xfer("amt_c2", pk(64, -64, 6, -6), 4, 1'b0, pk(32, -32, 0, 0), 1'b1, 1'b0);
        xfer("amt4_c0", pk(64, -64, 6, -6), 4, 1'b0, e_r4, 1'b0, 1'b0);
        xfer("amt4_c1", pk(64, -64, 6, -6), 1, 1'b0, e_r4, 1'b0, 1'b0);
        xfer("amt4_c2", pk(64, -64, 6, -6), 1, 1'b0, pk(4, -4, 0, 0), 1'b1, 1'b0);

        // backpressure for 5 cycles mid-vector
        xfer("bp_c0", pk(1, 2, 3, 4), 0, 1'b0, pk(1, 2, 3, 4), 1'b0, 1'b0);
        out_full = 1'b1;
        in_data  = pk(5, 6, 7, 8);
        #1;
        chk("bp_pending", 32'(req_chunk_out), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_no_pop", 32'(req_chunk_in), 32'd0);
            cyc();
            chk("bp_no_write", 32'(req_chunk_out), 32'd0);
        end
        chk("bp_hold", write_out_data, pk(1, 2, 3, 4));
        out_full = 1'b0;
        xfer("bp_c1", pk(5, 6, 7, 8), 0, 1'b0, pk(5, 6, 7, 8), 1'b0, 1'b0);
        xfer("bp_c2", pk(9, 10, 11, 12), 0, 1'b0, pk(9, 10, 0, 0), 1'b1, 1'b0);

        // reset mid-vector
        xfer("mr_c0", pk(1, 1, 1, 1), 0, 1'b0, pk(1, 1, 1, 1), 1'b0, 1'b0);
        xfer("mr_c1", pk(2, 2, 2, 2), 0, 1'b0, pk(2, 2, 2, 2), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mr_req_in", 32'(req_chunk_in), 32'd0);
        cyc();
        chk("mr_data", write_out_data, 32'd0);
        chk("mr_req_out", 32'(req_chunk_out), 32'd0);
        rst = 1'b0;
        xfer("mr_n0", pk(10, 20, 30, 40), 1, 1'b0, pk(5, 10, 15, 20), 1'b0, 1'b0);
        xfer("mr_n1", pk(10, 20, 30, 40), 1, 1'b0, pk(5, 10, 15, 20), 1'b0, 1'b0);
        xfer("mr_n2", pk(10, 20, 30, 40), 1, 1'b0, pk(5, 10, 0, 0), 1'b1, 1'b0);

        // random input gaps against the integer model
        for (int v = 0; v < 3; v++) begin
            ramt = $urandom_range(0, 9);
            rlft = 1'($urandom_range(0, 1));
            racc = 1'b0;
            for (int c = 0; c < 3; c++) begin
                rgap = $urandom_range(0, 3);
                in_data_ready = 1'b0;
                for (int g = 0; g < rgap; g++) begin
                    cyc();
                    chk("gap_idle", 32'(req_chunk_out), 32'd0);
                end
                rd   = $urandom;
                rexp = mchunk(rd, ramt, rlft, (c == 2) ? 2 : 4, rs);
                racc = racc | rs;
                if (c == 0) begin
                    xfer("rnd", rd, ramt, rlft, rexp, 1'b0, 1'b0);
                end else begin
                    xfer("rnd", rd, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                         rexp, (c == 2), (c == 2) ? racc : 1'b0);
                end
                if (out_vector_valid) n_vv++;
            end
        end
        in_data_ready = 1'b0;
        cyc();
        chk("rnd_vv_count", 32'(n_vv), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/v_shift_sat.md
# v_shift_sat

Streaming vector shift unit for the mlops datapath: consumes a vector of `InVecLength` signed fixed-point elements in chunks of `WorkingRegs` lanes from an upstream FIFO and writes the shifted chunks to a downstream FIFO. It generalises the fixed right-shift stage with a runtime shift amount and direction, left-shift saturation, a partial last chunk, and a registered output stage with backpressure. It sits between layer accumulators and requantisation/activation stages.

## Interface
- `InVecLength`, 16: elements per vector; any value ≥ 1.
- `WorkingRegs`, 4: lanes per chunk; any value ≥ 1.
- `NBits`, 8: signed element width.
- `clk_in` in 1: clock.
- `rst_in` in 1: synchronous, active-high reset.
- `in_data_ready` in 1: upstream FIFO non-empty; `in_data` is valid.
- `in_data` in `WorkingRegs`×`NBits`: signed input chunk.
- `shift_amt` in `$clog2(NBits)+1`: shift distance; sampled at the first chunk of each vector.
- `shift_left` in 1: 1 = left shift with saturation, 0 = arithmetic right shift; sampled with `shift_amt`.
- `out_full` in 1: downstream almost-full; guarantees one free slot after deassertion.
- `req_chunk_in` out 1: pop strobe for the upstream FIFO; combinational.
- `write_out_data` out `WorkingRegs`×`NBits`: registered, shifted chunk.
- `req_chunk_out` out 1: registered write strobe to the downstream FIFO.
- `out_vector_valid` out 1: registered; high with the write of the vector's last chunk.
- `out_sat` out 1: registered; high with `out_vector_valid` if any lane of that vector saturated.

## Operation
- `NChunks = ceil(InVecLength / WorkingRegs)`. The last chunk carries `InVecLength − (NChunks−1)·WorkingRegs` valid lanes. Unused upper lanes are output as 0 and never set saturation.
- `accept = in_data_ready && !out_full`. `req_chunk_in = accept`.
- States:
  - WAITING: no vector in flight. On `accept`, latch `shift_amt`/`shift_left` and process chunk 0. Go to PROCESSING if `NChunks > 1`; otherwise stay in WAITING.
  - PROCESSING: on `accept`, process chunk `chunk_idx` with the latched parameters. On the last chunk, clear `chunk_idx` and return to WAITING.
- Parameter changes mid-vector have no effect until the next WAITING accept.
- Right shift: arithmetic. Amounts ≥ `NBits` give sign fill (0 or −1). Amount 0 passes data through.
- Left shift: compute at `2·NBits` width, then clamp to [−2^(NBits−1), 2^(NBits−1)−1]. A clamped lane sets the sticky `sat_acc`. Amounts ≥ `NBits` saturate every nonzero lane.
- `sat_acc` clears at each vector start. `out_sat` reports `sat_acc` OR the last chunk's saturation.

## Timing
- Latency: 1 cycle from `accept` to `req_chunk_out`, `write_out_data`, and (on the last chunk) `out_vector_valid`/`out_sat`.
- Throughput: one chunk per cycle while `in_data_ready && !out_full`.
- `out_full` high: no pop. The chunk already registered is still written on the next cycle.
- `req_chunk_out` is high only in the cycle after an accept.
- Reset values: `write_out_data` = 0; `req_chunk_out`, `out_vector_valid`, `out_sat` = 0; state = WAITING; `chunk_idx` = 0; `sat_acc` = 0. `req_chunk_in` = 0 while `rst_in` is high.
- Reset mid-vector: the partial vector is discarded and the next accepted chunk is treated as chunk 0.
- `chunk_idx` wraps from `NChunks−1` to 0 only on an accept of the last chunk.

## Configuration
- `V_SHIFT_SAT_ROUND_EN`:
  - Defined: right shifts with `shift_amt ≥ 1` round half up. Add 2^(amt−1) before shifting; result cannot overflow. Amounts ≥ `NBits` give 0.
  - Undefined: right shifts truncate (floor).
- Left shifts are identical in both builds.

## Structure
- Shared `mlops_pkg`:
  - state enum `vproc_state_t {WAITING, PROCESSING}`
  - saturation bound functions `sat_max(NBits)` / `sat_min(NBits)`
- One sub-module, `lane_shift_sat`: a single combinational lane (shift, round, clamp, sat flag), instantiated `WorkingRegs` times.
- Control FSM, chunk counter, and output register live in the top module.

## Test plan
All scenarios use `NBits`=8, `WorkingRegs`=4, `InVecLength`=10 (3 chunks, last has 2 valid lanes).
- Right 2, FIFO always ready, chunks {8,−8,7,−7}, {…}, {…} → {2,−2,1,−2} without ROUND, {2,−2,2,−2} with ROUND. `req_chunk_out` on 3 consecutive cycles; `out_vector_valid` on the 3rd; lanes 2–3 of chunk 2 = 0.
- Left 3, lanes {20,−20,15,1} → {127,−128,120,8}; `out_sat`=1 at vector end. Next vector left 1, {3,3,3,3} → `out_sat`=0 (sticky cleared).
- `shift_amt` changes from 1 to 4 after chunk 0 → all three chunks use 1. New vector picks up 4.
- `out_full` asserted for 5 cycles mid-vector → no `req_chunk_in` during those cycles, one pending write, no lost or duplicated chunks; output order intact.
- `rst_in` pulsed after chunk 1 → outputs 0 next cycle. A fresh 3-chunk vector completes with `out_vector_valid` on its 3rd chunk.
- `in_data_ready` gaps of 0–3 random cycles between chunks → output data equals the reference model; exactly one `out_vector_valid` per 3 chunks.
